usb_warmboot_seq: RTL and testbench

Sequences USB attach at power-up and the clean detach-then-reconfigure on a boot request. It sits between the tinyfpga bootloader core and the iCE40 `SB_WARMBOOT` primitive on the Tomu/Fomu top level:
- It holds the D+ pull-up off until the board has settled.
- On a boot request it drops the pull-up and inhibits USB transmit long enough for the host to see a disconnect.
- It then drives the warmboot image select and `BOOT`.

---
 rtl/usb_warmboot_seq.sv | 202 ++++++++++++++++++++
 tb/tb_usb_warmboot_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_warmboot_seq.sv
// usb_warmboot_seq
//
// This block sequences USB attach at power-up. It also performs a clean
// detach-then-reconfigure when the bootloader core asks to boot another image.
//
// The D+ pull-up stays off until the board has settled. On a boot request,
// the block does the following in order:
//   - drops the pull-up and inhibits transmit for long enough that the host
//     sees a disconnect;
//   - presents the captured image index on the SB_WARMBOOT select pins;
//   - raises BOOT and holds it until the FPGA reconfigures.
//
// Parameters:
//   ATTACH_CYCLES  cycles from reset release to pull-up enable (>= 1)
//   DETACH_CYCLES  cycles the pull-up is held off before image select (>= 1)
//   SETTLE_CYCLES  cycles image select is stable before BOOT rises (>= 1)
//
// Ports:
//   clk_48mhz       in   sole clock, rising edge
//   reset           in   asynchronous active-high reset
//   boot_req        in   boot request, level-sampled
//   boot_image[1:0] in   warmboot image index, captured with boot_req
//   usb_pu          out  D+ pull-up enable
//   usb_tx_inhibit  out  forces the USB tristates to input
//   wb_s1, wb_s0    out  SB_WARMBOOT image select
//   wb_boot         out  SB_WARMBOOT BOOT
//   busy            out  high from request capture onward
//
// Build option:
//   WARMBOOT_REQ_SYNC_EN  When defined, boot_req and boot_image pass through
//                         a 2-flop synchronizer. Request latency becomes
//                         3 cycles.
//
// All outputs are registered. They are computed from the next state, so
// every output changes on the same edge as the state transition that
// implies it.

module usb_warmboot_seq #(
  parameter int ATTACH_CYCLES = 48000,
  parameter int DETACH_CYCLES = 480000,
  parameter int SETTLE_CYCLES = 48
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  output logic       usb_pu,
  output logic       usb_tx_inhibit,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy
);

  localparam int MAX_AD     = (ATTACH_CYCLES > DETACH_CYCLES) ? ATTACH_CYCLES : DETACH_CYCLES;
  localparam int MAX_CYCLES = (MAX_AD > SETTLE_CYCLES) ? MAX_AD : SETTLE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ATTACH_LOAD = cnt_t'(ATTACH_CYCLES - 1);
  localparam cnt_t DETACH_LOAD = cnt_t'(DETACH_CYCLES - 1);
  localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ATTACH_WAIT = 3'd0,
    ST_ATTACHED    = 3'd1,
    ST_DETACH      = 3'd2,
    ST_SETTLE      = 3'd3,
    ST_BOOT        = 3'd4
  } state_t;

  state_t     state, next_state;
  cnt_t       cnt, cnt_next;
  logic [1:0] image, image_next;
  logic       req;
  logic [1:0] req_image;
  logic       pu_next, inh_next, boot_next, busy_next;
  logic [1:0] sel_next;

`ifdef WARMBOOT_REQ_SYNC_EN
  // Two-stage synchronizer for sources that are asynchronous to clk_48mhz.
  // The image bits travel alongside the request. A request therefore always
  // sees the image that was presented with it.
  logic [1:0] req_sync;
  logic [1:0] img_sync0, img_sync1;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      req_sync  <= 2'b00;
      img_sync0 <= 2'b00;
      img_sync1 <= 2'b00;
    end else begin
      req_sync  <= {req_sync[0], boot_req};
      img_sync0 <= boot_image;
      img_sync1 <= img_sync0;
    end
  end

  assign req       = req_sync[1];
  assign req_image = img_sync1;
`else
  assign req       = boot_req;
  assign req_image = boot_image;
`endif

  // Next-state logic.
  // A request in ATTACH_WAIT wins over counter expiry in the same cycle.
  // BOOT has no exit; only reset leaves it.
  always_comb begin
    next_state = state;
    case (state)
      ST_ATTACH_WAIT: begin
        if (req)
          next_state = ST_DETACH;
        else if (cnt == '0)
          next_state = ST_ATTACHED;
      end
      ST_ATTACHED: begin
        if (req)
          next_state = ST_DETACH;
      end
      ST_DETACH: begin
        if (cnt == '0)
          next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0)
          next_state = ST_BOOT;
      end
      ST_BOOT: begin
        next_state = ST_BOOT;
      end
      default: begin
        next_state = ST_ATTACH_WAIT;
      end
    endcase
  end

  // Shared down-counter.
  // It is loaded with N-1 on entry to a timed state. The state is left on
  // the cycle the counter reads zero, so each timed state lasts exactly
  // N cycles. The image is captured only on the edge that leaves an idle
  // state for DETACH. After that edge it is frozen until reset.
  always_comb begin
    cnt_next   = cnt;
    image_next = image;
    if (next_state != state) begin
      case (next_state)
        ST_ATTACH_WAIT: cnt_next = ATTACH_LOAD;
        ST_DETACH:      cnt_next = DETACH_LOAD;
        ST_SETTLE:      cnt_next = SETTLE_LOAD;
        default:        cnt_next = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_next = cnt - cnt_t'(1);
    end
    if (next_state == ST_DETACH &&
        (state == ST_ATTACH_WAIT || state == ST_ATTACHED))
      image_next = req_image;
  end

  // Output decode from the next state, so that the output flops line up
  // with the state register.
  always_comb begin
    pu_next   = (next_state == ST_ATTACHED);
    inh_next  = (next_state != ST_ATTACHED);
    busy_next = (next_state == ST_DETACH) || (next_state == ST_SETTLE) ||
                (next_state == ST_BOOT);
    sel_next  = 2'b00;
    if (next_state == ST_SETTLE || next_state == ST_BOOT)
      sel_next = image_next;
    boot_next = (next_state == ST_BOOT);
  end

  // State, counter, image and output registers.
  // Reset drops any pending request and restarts the attach delay.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state          <= ST_ATTACH_WAIT;
      cnt            <= ATTACH_LOAD;
      image          <= 2'b00;
      usb_pu         <= 1'b0;
      usb_tx_inhibit <= 1'b1;
      wb_s1          <= 1'b0;
      wb_s0          <= 1'b0;
      wb_boot        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= cnt_next;
      image          <= image_next;
      usb_pu         <= pu_next;
      usb_tx_inhibit <= inh_next;
      wb_s1          <= sel_next[1];
      wb_s0          <= sel_next[0];
      wb_boot        <= boot_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_usb_warmboot_seq.sv
// tb_usb_warmboot_seq
//
// Testbench for usb_warmboot_seq. It uses the parameters ATTACH=8,
// DETACH=16 and SETTLE=4.
//
// Expected output vectors {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot,
// busy} come from a small cycle model. They are pushed into a scoreboard
// queue when stimulus is driven, and popped and compared one per clock edge.
// Outputs are sampled 1 time unit after each rising edge.
//
// Build option: when WARMBOOT_REQ_SYNC_EN is defined, the expected request
// latency grows by two synchronizer cycles.

module tb_usb_warmboot_seq;

  localparam int ATTACH = 8;
  localparam int DETACH = 16;
  localparam int SETTLE = 4;
`ifdef WARMBOOT_REQ_SYNC_EN
  localparam int REQ_LAT = 3;
`else
  localparam int REQ_LAT = 1;
`endif
  localparam logic [5:0] RESET_VEC = 6'b010000;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       boot_req;
  logic [1:0] boot_image;
  logic       usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [5:0] sb[$];
  logic [5:0] exp_v, obs_v;

  usb_warmboot_seq #(
    .ATTACH_CYCLES(ATTACH),
    .DETACH_CYCLES(DETACH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset(reset),
    .boot_req(boot_req),
    .boot_image(boot_image),
    .usb_pu(usb_pu),
    .usb_tx_inhibit(usb_tx_inhibit),
    .wb_s1(wb_s1),
    .wb_s0(wb_s0),
    .wb_boot(wb_boot),
    .busy(busy)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Expected outputs e edges after reset release, given the edge on which
  // the FSM takes a request (cap < 0 means no request).
  function automatic logic [5:0] model(int e, int cap, logic [1:0] img);
    logic pu;
    if (cap < 0 || e < cap) begin
      pu = (e >= ATTACH);
      return {pu, ~pu, 2'b00, 1'b0, 1'b0};
    end
    return {1'b0, 1'b1, (e >= cap + DETACH) ? img : 2'b00,
            (e >= cap + DETACH + SETTLE), 1'b1};
  endfunction

  task automatic tick;
    @(posedge clk_48mhz);
    #1;
    cyc++;
  endtask

  // Hold reset across two edges and release it just after an edge.
  // The next edge is then edge 1.
  task automatic do_reset;
    reset    = 1'b1;
    boot_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset;
    boot_req   = 1'b0;
    boot_image = 2'b00;
    reset      = 1'b1;
    #2;
    sb.push_back(RESET_VEC);
    exp_v = sb.pop_front();
    obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("[TB] FAIL reset_values: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_power_up;
    do_reset();
    for (int e = 0; e <= ATTACH + 6; e++) sb.push_back(model(e, -1, 2'b00));
    for (int e = 0; e <= ATTACH + 6; e++) begin
      if (e > 0) tick();
      exp_v = sb.pop_front();
      obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("[TB] FAIL power_up edge %0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_normal_boot;
    int cap;
    do_reset();
    while (cyc < ATTACH + 2) tick();
    boot_image = 2'b10;
    boot_req   = 1'b1;
    cap = cyc + REQ_LAT;
    for (int e = cyc + 1; e <= cap + DETACH + SETTLE + 100; e++)
      sb.push_back(model(e, cap, 2'b10));
    while (sb.size() > 0) begin
      tick();
      boot_req = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("[TB] FAIL normal_boot edge %0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_early_request;
    int cap;
    do_reset();
    while (cyc < 3) tick();
    boot_image = 2'b01;
    boot_req   = 1'b1;
    cap = cyc + REQ_LAT;
    for (int e = cyc + 1; e <= cap + DETACH + SETTLE + 4; e++)
      sb.push_back(model(e, cap, 2'b01));
    while (sb.size() > 0) begin
      tick();
      boot_req = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("[TB] FAIL early_request edge %0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  // Later requests with a different image arrive during DETACH and SETTLE.
  // They must change nothing.
  task automatic test_ignored_rerequest;
    int cap;
    do_reset();
    while (cyc < ATTACH + 1) tick();
    boot_image = 2'b11;
    boot_req   = 1'b1;
    cap = cyc + REQ_LAT;
    for (int e = cyc + 1; e <= cap + DETACH + SETTLE + 6; e++)
      sb.push_back(model(e, cap, 2'b11));
    while (sb.size() > 0) begin
      tick();
      boot_req = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("[TB] FAIL ignored_rerequest edge %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (cyc == cap + 5 || cyc == cap + DETACH + 1) begin
        boot_req   = 1'b1;
        boot_image = 2'b00;
      end
    end
  endtask

  // Reset is asserted at DETACH cycle 7 and again in BOOT. Each time the
  // outputs must drop asynchronously, and attach must then repeat cleanly.
  task automatic test_reset_mid;
    int cap;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      while (cyc < ATTACH + 1) tick();
      boot_image = 2'b01;
      boot_req   = 1'b1;
      cap = cyc + REQ_LAT;
      for (int e = cyc + 1; e <= cap + ((pass == 0) ? 7 : DETACH + SETTLE + 3); e++)
        sb.push_back(model(e, cap, 2'b01));
      while (sb.size() > 0) begin
        tick();
        boot_req = 1'b0;
        exp_v = sb.pop_front();
        obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
        total++;
        if (obs_v !== exp_v) begin
          bad++;
          $display("[TB] FAIL reset_mid run%0d edge %0d: got %b want %b", pass, cyc, obs_v, exp_v);
        end
      end
      #3;
      reset = 1'b1;
      sb.push_back(RESET_VEC);
      #1;
      exp_v = sb.pop_front();
      obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("[TB] FAIL async_reset run%0d: got %b want %b", pass, obs_v, exp_v);
      end
      tick();
      reset = 1'b0;
      cyc   = 0;
      for (int e = 1; e <= ATTACH + 4; e++) sb.push_back(model(e, -1, 2'b00));
      while (sb.size() > 0) begin
        tick();
        exp_v = sb.pop_front();
        obs_v = {usb_pu, usb_tx_inhibit, wb_s1, wb_s0, wb_boot, busy};
        total++;
        if (obs_v !== exp_v) begin
          bad++;
          $display("[TB] FAIL reattach run%0d edge %0d: got %b want %b", pass, cyc, obs_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] usb_warmboot_seq bench, request latency %0d", REQ_LAT);
    test_reset();
    test_power_up();
    test_normal_boot();
    test_early_request();
    test_ignored_rerequest();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
